// File: rtl/data_mem_io.sv
// Data-memory responder for the RV32I data port: byte-writable word RAM
// plus a small I/O window (LED register, free-running cycle counter and an
// 8N1 UART transmitter). Read data is returned one cycle after the address.
module data_mem_io #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] IO_BASE   = 32'h8000_0000,
    parameter int          CLK_DIV   = 104
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr,
    input  logic [3:0]  data_wr_en,
    output logic [31:0] data_rd,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int          BW        = $clog2(CLK_DIV);
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [29:0] LED_WORD  = IO_BASE[31:2];
    localparam logic [29:0] CNT_WORD  = LED_WORD + 30'd1;
    localparam logic [29:0] UART_WORD = LED_WORD + 30'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // ------------------------------------------------------------------
    // Address decode (RAM wins if the I/O window were ever placed inside it)
    // ------------------------------------------------------------------
    logic sel_ram;
    logic sel_led;
    logic sel_cnt;
    logic sel_uart;
    logic any_we;

    assign sel_ram  = ({1'b0, data_addr} < RAM_BYTES);
    assign sel_led  = !sel_ram && (data_addr[31:2] == LED_WORD);
    assign sel_cnt  = !sel_ram && (data_addr[31:2] == CNT_WORD);
    assign sel_uart = !sel_ram && (data_addr[31:2] == UART_WORD);
    assign any_we   = |data_wr_en;

    // ------------------------------------------------------------------
    // Word RAM with per-lane write enables and registered read
    // ------------------------------------------------------------------
    logic [31:0]   ram [MEM_WORDS];
    logic [31:0]   ram_rd_reg;
    logic [AW-1:0] ram_idx;
    logic [3:0]    lane_we;

    assign ram_idx = data_addr[AW+1:2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
            assign lane_we[gi] = sel_ram & data_wr_en[gi];
        end
    endgenerate

    // RAM port: read old word (read-before-write) and update enabled lanes
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                ram[ram_idx][8*i +: 8] <= data_wr[8*i +: 8];
            end
        end
        ram_rd_reg <= ram[ram_idx];
    end

    // ------------------------------------------------------------------
    // LED register and cycle counter
    // ------------------------------------------------------------------
    logic [7:0]  leds_reg;
    logic [7:0]  leds_next;
    logic [31:0] cnt_reg;
    logic [31:0] cnt_next;

    // Next values: LED takes lane 0 only; any write to the counter clears it
    always_comb begin
        leds_next = leds_reg;
        cnt_next  = cnt_reg + 32'd1;
        if (sel_led && data_wr_en[0]) begin
            leds_next = data_wr[7:0];
        end
        if (sel_cnt && any_we) begin
            cnt_next = 32'd0;
        end
    end

    // LED / counter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            leds_reg <= 8'd0;
            cnt_reg  <= 32'd0;
        end else begin
            leds_reg <= leds_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign leds = leds_reg;

    // ------------------------------------------------------------------
    // UART transmitter, 8N1, LSB first
    // ------------------------------------------------------------------
    uart_state_t   state_reg;
    uart_state_t   state_next;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_next;
    logic [2:0]    bit_idx_reg;
    logic [2:0]    bit_idx_next;
    logic [BW-1:0] baud_reg;
    logic [BW-1:0] baud_next;
    logic          tx_reg;
    logic          tx_next;
    logic          busy;
    logic          baud_last;
    logic          uart_wr;

    assign busy      = (state_reg != IDLE);
    assign baud_last = (baud_reg == BW'(CLK_DIV - 1));
    assign uart_wr   = sel_uart && data_wr_en[0];

    // UART state register; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= 8'd0;
            bit_idx_reg <= 3'd0;
            baud_reg    <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            baud_reg    <= baud_next;
            tx_reg      <= tx_next;
        end
    end

    // UART next-state logic; the line level is computed a cycle ahead so
    // uart_tx comes straight from a flop
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        baud_next    = baud_reg;
        tx_next      = tx_reg;
        case (state_reg)
            IDLE: begin
                if (uart_wr) begin
                    shift_next   = data_wr[7:0];
                    bit_idx_next = 3'd0;
                    baud_next    = '0;
                    tx_next      = 1'b0;
                    state_next   = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_next    = '0;
                    bit_idx_next = 3'd0;
                    tx_next      = shift_reg[0];
                    state_next   = DATA;
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign uart_tx = tx_reg;

    // ------------------------------------------------------------------
    // Read path: I/O value registered here, RAM word from the RAM port
    // ------------------------------------------------------------------
    logic [31:0] io_rd_next;
    logic [31:0] io_rd_reg;
    logic        rd_ram_reg;

    // I/O read mux; counter returns its value before the sampling edge
    always_comb begin
        io_rd_next = 32'd0;
        if (sel_led) begin
            io_rd_next = {24'd0, leds_reg};
        end else if (sel_cnt) begin
            io_rd_next = cnt_reg;
        end else if (sel_uart) begin
            io_rd_next = {31'd0, busy};
        end
    end

    // Read-source select and I/O read register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ram_reg <= 1'b0;
            io_rd_reg  <= 32'd0;
        end else begin
            rd_ram_reg <= sel_ram;
            io_rd_reg  <= io_rd_next;
        end
    end

    assign data_rd = rd_ram_reg ? ram_rd_reg : io_rd_reg;

endmodule

// File: tb/tb_data_mem_io.sv
// Bench for data_mem_io: directed transactions, a cycle-level reference
// model of the memory map, and a per-cycle output comparison.
module tb_data_mem_io;

    localparam int          MEM_WORDS = 64;
    localparam logic [31:0] IO_BASE   = 32'h8000_0000;
    localparam int          CLK_DIV   = 4;
    localparam logic [31:0] A_LED     = IO_BASE;
    localparam logic [31:0] A_CNT     = IO_BASE + 32'd4;
    localparam logic [31:0] A_UART    = IO_BASE + 32'd8;
    localparam logic [31:0] A_NONE    = IO_BASE + 32'hC;

    logic        clk;
    logic        rst;
    logic [31:0] data_addr;
    logic [31:0] data_wr;
    logic [3:0]  data_wr_en;
    logic [31:0] data_rd;
    logic [7:0]  leds;
    logic        uart_tx;

    int checks = 0;
    int errors = 0;

    data_mem_io #(
        .MEM_WORDS(MEM_WORDS),
        .IO_BASE  (IO_BASE),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_addr (data_addr),
        .data_wr   (data_wr),
        .data_wr_en(data_wr_en),
        .data_rd   (data_rd),
        .leds      (leds),
        .uart_tx   (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: state after each rising edge
    // ------------------------------------------------------------------
    logic [31:0] m_mem [MEM_WORDS];
    logic [31:0] m_rd;
    logic [7:0]  m_leds;
    logic [31:0] m_cnt;
    logic        m_active;
    int          m_t;
    logic [9:0]  m_frame;
    logic        m_valid;
    logic [31:0] m_widx;
    logic        m_was_active;

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = 32'd0;
        m_valid  = 1'b0;
        m_rd     = 32'd0;
        m_leds   = 8'd0;
        m_cnt    = 32'd0;
        m_active = 1'b0;
        m_t      = 0;
        m_frame  = 10'h3FF;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_rd     = 32'd0;
            m_leds   = 8'd0;
            m_cnt    = 32'd0;
            m_active = 1'b0;
            m_t      = 0;
            m_valid  = 1'b1;
        end else begin
            m_widx = data_addr >> 2;
            if (data_addr < MEM_WORDS * 4)        m_rd = m_mem[m_widx];
            else if (m_widx == (A_LED >> 2))      m_rd = {24'd0, m_leds};
            else if (m_widx == (A_CNT >> 2))      m_rd = m_cnt;
            else if (m_widx == (A_UART >> 2))     m_rd = {31'd0, m_active};
            else                                  m_rd = 32'd0;

            m_was_active = m_active;
            if (m_active) begin
                m_t = m_t + 1;
                if (m_t == 10 * CLK_DIV) m_active = 1'b0;
            end

            if (data_addr < MEM_WORDS * 4) begin
                for (int l = 0; l < 4; l++)
                    if (data_wr_en[l]) m_mem[m_widx][8*l +: 8] = data_wr[8*l +: 8];
            end
            if (m_widx == (A_LED >> 2) && data_wr_en[0]) m_leds = data_wr[7:0];
            if (m_widx == (A_CNT >> 2) && data_wr_en != 4'd0) m_cnt = 32'd0;
            else m_cnt = m_cnt + 32'd1;
            if (!m_was_active && m_widx == (A_UART >> 2) && data_wr_en[0]) begin
                m_active = 1'b1;
                m_t      = 0;
                m_frame  = {1'b1, data_wr[7:0], 1'b0};
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (data_rd !== m_rd) begin
                errors++;
                $display("FAIL model_rd t=%0t got=%h exp=%h", $time, data_rd, m_rd);
            end
            checks++;
            if (leds !== m_leds) begin
                errors++;
                $display("FAIL model_leds t=%0t got=%h exp=%h", $time, leds, m_leds);
            end
            checks++;
            if (uart_tx !== (m_active ? m_frame[m_t / CLK_DIV] : 1'b1)) begin
                errors++;
                $display("FAIL model_tx t=%0t got=%b exp=%b", $time, uart_tx,
                         (m_active ? m_frame[m_t / CLK_DIV] : 1'b1));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic [3:0] e);
        data_addr  = a;
        data_wr    = w;
        data_wr_en = e;
        @(negedge clk);
        $display("txn addr=%h wr=%h en=%b -> rd=%h leds=%h tx=%b", a, w, e, data_rd, leds, uart_tx);
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    logic [31:0] cnt_a;
    logic [31:0] cnt_b;
    logic [9:0]  pat;

    initial begin
        rst        = 1'b1;
        data_addr  = 32'd0;
        data_wr    = 32'd0;
        data_wr_en = 4'd0;
        repeat (3) drive(32'd0, 32'd0, 4'd0);
        rst = 1'b0;
        lit("reset_rd", data_rd, 32'd0);
        lit("reset_leds", {24'd0, leds}, 32'd0);
        lit("reset_tx", {31'd0, uart_tx}, 32'd1);

        // RAM byte lanes
        drive(32'h10, 32'hDEAD_BEEF, 4'b1111);
        drive(32'h10, 32'h0000_5500, 4'b0010);
        lit("ram_rbw_full", data_rd, 32'hDEAD_BEEF);
        drive(32'h10, 32'd0, 4'b0000);
        lit("ram_lanes", data_rd, 32'hDEAD_55EF);

        // Read-before-write
        drive(32'h20, 32'h1, 4'b1111);
        lit("rbw_old", data_rd, 32'd0);
        drive(32'h20, 32'd0, 4'b0000);
        lit("rbw_new", data_rd, 32'd1);

        // LED and unmapped space
        drive(A_LED, 32'h0000_01A5, 4'b0011);
        lit("led_write", {24'd0, leds}, 32'hA5);
        drive(A_LED, 32'd0, 4'b0000);
        lit("led_read", data_rd, 32'h0000_00A5);
        drive(A_NONE, 32'hFFFF_FFFF, 4'b1111);
        lit("unmapped_leds", {24'd0, leds}, 32'hA5);
        drive(A_NONE, 32'd0, 4'b0000);
        lit("unmapped_read", data_rd, 32'd0);

        // Counter: reads five cycles apart differ by five
        drive(A_CNT, 32'd0, 4'b0000);
        cnt_a = data_rd;
        repeat (4) drive(32'd0, 32'd0, 4'd0);
        drive(A_CNT, 32'd0, 4'b0000);
        cnt_b = data_rd;
        lit("cnt_delta", cnt_b - cnt_a, 32'd5);

        // Counter clear: read three cycles after the write returns 2
        drive(A_CNT, 32'd0, 4'b0001);
        drive(32'd0, 32'd0, 4'd0);
        drive(32'd0, 32'd0, 4'd0);
        drive(A_CNT, 32'd0, 4'b0000);
        lit("cnt_clear", data_rd, 32'd2);

        // Counter wrap: preload all-ones, next cycle shows zero
        dut.cnt_reg = 32'hFFFF_FFFF;
        m_cnt       = 32'hFFFF_FFFF;
        drive(A_CNT, 32'd0, 4'b0000);
        lit("cnt_max", data_rd, 32'hFFFF_FFFF);
        drive(A_CNT, 32'd0, 4'b0000);
        lit("cnt_wrap", data_rd, 32'd0);

        // UART frame of 8'h53; a second write mid-frame is ignored
        pat = 10'b1010100110;
        drive(A_UART, 32'h0000_0053, 4'b0001);
        for (int k = 0; k < 10 * CLK_DIV; k++) begin
            lit($sformatf("uart_bit%0d", k), {31'd0, uart_tx}, {31'd0, pat[k / CLK_DIV]});
            if (k == 8) drive(A_UART, 32'h0000_00FF, 4'b0001);
            else        drive(A_UART, 32'd0, 4'b0000);
            lit($sformatf("uart_busy%0d", k), data_rd, 32'd1);
        end
        lit("uart_idle_tx", {31'd0, uart_tx}, 32'd1);
        drive(A_UART, 32'd0, 4'b0000);
        lit("uart_not_busy", data_rd, 32'd0);

        // Reset mid-frame
        drive(A_UART, 32'h0000_00A5, 4'b0001);
        repeat (9) drive(32'd0, 32'd0, 4'd0);
        lit("frame_running", {31'd0, uart_tx}, 32'd0);
        rst = 1'b1;
        drive(32'd0, 32'd0, 4'd0);
        rst = 1'b0;
        lit("rst_tx", {31'd0, uart_tx}, 32'd1);
        lit("rst_leds", {24'd0, leds}, 32'd0);
        drive(A_CNT, 32'd0, 4'b0000);
        lit("rst_cnt", data_rd, 32'd0);
        drive(A_UART, 32'd0, 4'b0000);
        lit("rst_busy", data_rd, 32'd0);
        drive(32'h10, 32'd0, 4'b0000);
        lit("rst_ram_kept", data_rd, 32'hDEAD_55EF);
        drive(32'h20, 32'd0, 4'b0000);
        lit("rst_ram_kept2", data_rd, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
